// File: rtl/refill_beat_assembler.sv
// refill_beat_assembler: packs BEATS in-order response beats into one refill line with its id.
// Define REFILL_ASM_FRAME_CHK_EN to report beat-framing errors on asm_err.
module refill_beat_assembler #(
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256,
  parameter int BEATS  = 4,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [ID_W-1:0]   mem_rsp_id,
  input  logic [BEAT_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_last,
  output logic              memctl_refill_valid,
  input  logic              memctl_refill_ready,
  output logic [ID_W-1:0]   memctl_refill_id,
  output logic [LINE_W-1:0] memctl_refill_data,
  output logic              asm_err
);
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              err_q, err_d;
  logic              acc, drop;

  // In FULL a beat is only taken alongside the handshake, so it can start the next line.
  assign mem_rsp_ready       = (state_q == FULL) ? memctl_refill_ready : 1'b1;
  assign acc                 = mem_rsp_valid & mem_rsp_ready;
  assign memctl_refill_valid = state_q == FULL;
  assign memctl_refill_id    = id_q;
  assign memctl_refill_data  = data_q;
  assign asm_err             = err_q;

`ifdef REFILL_ASM_FRAME_CHK_EN
  assign drop  = acc & mem_rsp_last & (cnt_q != LAST_CNT);
  assign err_d = drop | (acc & ((~mem_rsp_last & (cnt_q == LAST_CNT)) |
                                ((cnt_q != '0) & (mem_rsp_id != id_q))));
`else
  logic unused_last;
  assign unused_last = mem_rsp_last;
  assign drop        = 1'b0;
  assign err_d       = 1'b0;
`endif

  // cnt_q is zero in IDLE and FULL, so it always names the slot of the incoming beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    id_d    = id_q;
    if (acc) data_d[cnt_q*BEAT_W +: BEAT_W] = mem_rsp_data;
    if (acc && cnt_q == '0) id_d = mem_rsp_id;
    if (drop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (acc) begin
      state_d = (cnt_q == LAST_CNT) ? FULL : FILL;
      cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end else if (state_q == FULL && memctl_refill_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end
endmodule
